// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch FIFO.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of fetch_entry_t: power-of-two depth, synchronous flush, async reset.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  storage_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    count    = count_q;
    head     = storage_q[rd_ptr_q];
    do_pop   = pop && !empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) storage_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage producer: credit-limited imem requests, prefetch FIFO, redirect flush.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flushed
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, redirect_target;
  logic [CW-1:0] outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d, fifo_count;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic          credit_ok, req_fire, rsp_fire, rsp_drop;
  fetch_entry_t  fifo_head, push_entry;

  assign redirect_target = redirect_pc & ~32'h3;

  // Handshakes: a request moves when imem_req_valid && imem_req_ready at a rising
  // edge; an instruction moves when if_valid && if_ready. Valid never waits on ready.
  always_comb begin
    credit_ok = (({1'b0, outstanding_q} + {1'b0, fifo_count}) < SW'(FIFO_DEPTH)) &&
                (outstanding_q < CW'(MAX_OUTSTANDING));
    imem_req_valid = !reset && !redirect_valid && credit_ok;
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_fire       = imem_rsp_valid && (outstanding_q != '0);
    rsp_drop       = rsp_fire && (drop_cnt_q != '0);
    fifo_push      = rsp_fire && !rsp_drop && !redirect_valid && !fifo_full;
    push_entry     = '{instr: imem_rsp_data, pc: rsp_pc_q};
    if_valid       = !fifo_empty && !redirect_valid;
    fifo_pop       = if_valid && if_ready;
    if_instruction = fifo_empty ? '0 : fifo_head.instr;
    if_pc_plus4    = fifo_empty ? '0 : fifo_head.pc + XLEN'(INSTR_BYTES);

    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    if (redirect_valid) begin
      // Every request still in flight after this edge belongs to the old stream.
      fetch_pc_d = redirect_target;
      rsp_pc_d   = redirect_target;
      drop_cnt_d = outstanding_d;
    end else begin
      if (req_fire)  fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
      if (rsp_drop)  drop_cnt_d = drop_cnt_q - CW'(1);
      if (fifo_push) rsp_pc_d   = rsp_pc_q + XLEN'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(fifo_pop);
    perf_stall_d   = perf_stall_q + 32'(if_valid && !if_ready);
    // On redirect the buffered entries and any response landing that cycle are lost.
    if (redirect_valid) perf_flushed_d = perf_flushed_q + 32'(fifo_count) + 32'(rsp_fire);
    else                perf_flushed_d = perf_flushed_q + 32'(rsp_drop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched      = perf_fetched_q;
  assign perf_stall_cycles = perf_stall_q;
  assign perf_flushed      = perf_flushed_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: memory model plus a stream-level reference
// (in-flight list tagged stale on redirect, expected-output queue).
module tb_instruction_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 4;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_instruction, if_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall_cycles, perf_flushed;
`endif

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instruction(if_instruction), .if_pc_plus4(if_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall_cycles(perf_stall_cycles),
    .perf_flushed(perf_flushed)
`endif
  );

  typedef struct { logic [31:0] pc; bit stale; } flight_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  flight_t     inflight_q[$];
  logic [63:0] exp_q[$];
  mreq_t       mem_q[$];
  logic [31:0] exp_fetch_pc;
  logic [31:0] m_fetched, m_stall, m_flushed;
  int          checks = 0, errors = 0, cyc = 0, last_due = 0;
  int          lat_lo = 1, lat_hi = 1;
  bit          last_hs, last_ifv;
  logic [31:0] last_hs_addr, last_pc4;
  int          last_hs_cyc, last_ifv_cyc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(output bit exp_req, output bit exp_ifv);
    exp_req = !redirect_valid && (inflight_q.size() + exp_q.size() < DEPTH) &&
              (inflight_q.size() < MAX_OUT);
    exp_ifv = (exp_q.size() != 0) && !redirect_valid;
    chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) chk("req_addr", imem_req_addr, exp_fetch_pc);
    chk("if_valid", 32'(if_valid), 32'(exp_ifv));
    if (exp_q.size() != 0) begin
      chk("if_instruction", if_instruction, exp_q[0][63:32]);
      chk("if_pc_plus4", if_pc_plus4, exp_q[0][31:0] + 32'd4);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_stall", perf_stall_cycles, m_stall);
    chk("perf_flushed", perf_flushed, m_flushed);
`endif
  endtask

  task automatic check_reset_state();
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_if_valid", 32'(if_valid), 0);
    chk("rst_instruction", if_instruction, 0);
    chk("rst_pc_plus4", if_pc_plus4, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetched", perf_fetched, 0);
    chk("rst_perf_stall", perf_stall_cycles, 0);
    chk("rst_perf_flushed", perf_flushed, 0);
`endif
  endtask

  // One clock cycle: called just after a falling edge with inputs already set.
  task automatic step();
    bit exp_req, exp_ifv, hs, rsp, rst;
    logic [31:0] addr;
    int due;
    flight_t f;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    rst = reset;
    exp_req = 1'b0;
    exp_ifv = 1'b0;
    if (rst) check_reset_state();
    else     check_outputs(exp_req, exp_ifv);
    hs = imem_req_valid && imem_req_ready;
    rsp = imem_rsp_valid;
    addr = imem_req_addr;
    last_hs = hs; last_hs_addr = addr; last_hs_cyc = cyc;
    last_ifv = if_valid; last_pc4 = if_pc_plus4; last_ifv_cyc = cyc;
    @(posedge clk);
    if (rsp) void'(mem_q.pop_front());
    if (hs) begin
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (due < last_due) due = last_due;
      last_due = due;
      mem_q.push_back('{addr, due});
    end
    cyc++;
    if (rst) begin
      inflight_q.delete();
      exp_q.delete();
      exp_fetch_pc = RST_PC;
      m_fetched = 0; m_stall = 0; m_flushed = 0;
    end else if (redirect_valid) begin
      m_flushed += 32'(exp_q.size());
      if (rsp && inflight_q.size() != 0) begin
        void'(inflight_q.pop_front());
        m_flushed += 1;
      end
      foreach (inflight_q[i]) inflight_q[i].stale = 1'b1;
      exp_q.delete();
      exp_fetch_pc = redirect_pc & ~32'h3;
    end else begin
      if (exp_ifv && !if_ready) m_stall += 1;
      if (exp_ifv && if_ready) begin
        void'(exp_q.pop_front());
        m_fetched += 1;
      end
      if (rsp && inflight_q.size() != 0) begin
        f = inflight_q.pop_front();
        if (f.stale) m_flushed += 1;
        else exp_q.push_back({mem_word(f.pc), f.pc});
      end
      if (exp_req && imem_req_ready) begin
        inflight_q.push_back('{exp_fetch_pc, 1'b0});
        exp_fetch_pc += 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_hs(input string tag, input logic [31:0] exp_addr);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (last_hs) seen = 1'b1;
    end
    chk({tag, "_seen"}, 32'(seen), 1);
    if (seen) chk(tag, last_hs_addr, exp_addr);
  endtask

  task automatic wait_ifv(input string tag, input logic [31:0] exp_pc4);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (last_ifv) seen = 1'b1;
    end
    chk({tag, "_seen"}, 32'(seen), 1);
    if (seen) chk(tag, last_pc4, exp_pc4);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) step();
    reset = 1'b0;
  endtask

  initial begin
    int c0, nhs;
    reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    exp_fetch_pc = RST_PC; m_fetched = 0; m_stall = 0; m_flushed = 0;
    @(negedge clk);

    // 1: streaming, 1-cycle memory, consumer always ready
    do_reset(3);
    imem_req_ready = 1'b1; if_ready = 1'b1; lat_lo = 1; lat_hi = 1;
    wait_hs("t1_first_addr", RST_PC);
    c0 = last_hs_cyc;
    wait_ifv("t1_first_pc4", RST_PC + 32'd4);
    chk("t1_latency", 32'(last_ifv_cyc - c0), 2);
    for (int i = 0; i < 12; i++) step();

    // 2: consumer stall fills exactly the credit window
    do_reset(1);
    if_ready = 1'b0; nhs = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_hs) nhs++;
    end
    chk("t2_accepts", 32'(nhs), DEPTH);
    chk("t2_req_dropped", 32'(imem_req_valid), 0);
    if_ready = 1'b1;
    wait_hs("t2_resume_addr", 32'h10);
    for (int i = 0; i < 6; i++) step();

    // 3: 3-cycle memory, redirect with 3 in flight and 1 buffered
    do_reset(1);
    lat_lo = 3; lat_hi = 3; if_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t3_buffered", 32'(if_valid), 1);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    wait_hs("t3_new_addr", 32'h100);
    if_ready = 1'b1;
    wait_ifv("t3_first_pc4", 32'h104);
    for (int i = 0; i < 8; i++) step();

    // 4: unaligned redirect colliding with a pop
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 6; i++) step();
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    step();
    chk("t4_no_pop_if_valid", 32'(last_ifv), 0);
    redirect_valid = 1'b0;
    wait_hs("t4_new_addr", 32'h200);
    wait_ifv("t4_first_pc4", 32'h204);

    // 5: reset mid-stream, stale responses after reset must be ignored
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 8; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0; imem_req_ready = 1'b0;
    for (int i = 0; i < 10 && mem_q.size() != 0; i++) step();
    step();
    chk("t5_if_valid_after_stale", 32'(if_valid), 0);
    imem_req_ready = 1'b1; lat_lo = 1; lat_hi = 1;
    wait_hs("t5_restart_addr", RST_PC);
    wait_ifv("t5_first_pc4", RST_PC + 32'd4);

    // 6: stall with if_valid for 10 cycles, then redirect over 4 buffered entries
    do_reset(1);
    if_ready = 1'b0;
    wait_ifv("t6_first_pc4", RST_PC + 32'd4);
    for (int i = 0; i < 9; i++) step();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    chk("t6_perf_stall", perf_stall_cycles, 10);
    chk("t6_perf_flushed", perf_flushed, 4);
    chk("t6_perf_fetched", perf_fetched, 0);
`endif
    if_ready = 1'b1;
    wait_hs("t6_new_addr", 32'h40);

    // 7: random traffic against the reference model
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 400; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if_ready       = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = $urandom;
      step();
    end
    redirect_valid = 1'b0; if_ready = 1'b1; imem_req_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
